// File: rtl/rev_pkg.sv
// rev_pkg: shared mode encoding and sizing helpers for the rev_stream block.
//   rev_mode_t  : per-word transform select (2 bits)
//   group_count : number of groups in a word
//   ptr_width   : FIFO pointer width for a given depth
//   level_width : occupancy counter width for a given depth
package rev_pkg;

    typedef enum logic [1:0] {
        REV_PASS     = 2'd0,
        REV_BIT      = 2'd1,
        REV_GROUP    = 2'd2,
        REV_IN_GROUP = 2'd3
    } rev_mode_t;

    localparam int REV_MODE_W = 2;

    function automatic int group_count(input int data_width, input int group_width);
        return data_width / group_width;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rev_stream_if.sv
// rev_stream_if: producer/consumer handshake bundle for rev_stream.
//   in_valid/in_ready/in_data/in_mode     : upstream word and its transform select
//   out_valid/out_ready/out_data/out_mode : head-of-FIFO word and its mode
//   level                                 : FIFO occupancy
//   modport slave  : the rev_stream side
//   modport master : the producer/consumer side
interface rev_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
);
    import rev_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_WIDTH-1:0]         in_data;
    logic [REV_MODE_W-1:0]         in_mode;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [REV_MODE_W-1:0]         out_mode;
    logic [level_width(DEPTH)-1:0] level;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, level
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, level
    );

endinterface

// File: rtl/rev_xform.sv
// rev_xform: combinational bit-reorder of one word.
//   din  : input word
//   mode : PASS, full bit reverse, group-order reverse, or bit reverse within groups
//   dout : transformed word
module rev_xform
    import rev_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int GROUP_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] din,
    input  rev_mode_t             mode,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int G = group_count(DATA_WIDTH, GROUP_WIDTH);

    logic [DATA_WIDTH-1:0] bit_rev;
    logic [DATA_WIDTH-1:0] grp_rev;
    logic [DATA_WIDTH-1:0] ing_rev;

    // Output bit i sits in group gi at offset bi; each mode picks its source bit.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        localparam int GI = i / GROUP_WIDTH;
        localparam int BI = i % GROUP_WIDTH;
        assign bit_rev[i] = din[DATA_WIDTH-1-i];
        assign grp_rev[i] = din[(G-1-GI)*GROUP_WIDTH + BI];
        assign ing_rev[i] = din[GI*GROUP_WIDTH + GROUP_WIDTH-1-BI];
    end

    always_comb begin
        dout = mode == REV_BIT      ? bit_rev :
               mode == REV_GROUP    ? grp_rev :
               mode == REV_IN_GROUP ? ing_rev : din;
    end

`ifdef FORMAL
    always_comb begin
        if (mode == REV_BIT) assert (dout[0] == din[DATA_WIDTH-1]);
    end
`endif

endmodule

// File: rtl/rev_stream.sv
// rev_stream: streaming bit-reorder unit with an output FIFO.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset, clears FIFO contents and pointers
//   bus    : rev_stream_if slave (input handshake, output handshake, level)
// Words are transformed on entry and stored with their mode; in_ready and
// out_valid depend only on the registered occupancy.
module rev_stream
    import rev_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int GROUP_WIDTH = 4,
    parameter int DEPTH       = 2
) (
    input  logic          clk,
    input  logic          resetn,
    rev_stream_if.slave   bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [DATA_WIDTH-1:0] xdata;
    logic                  push;
    logic                  pop;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [REV_MODE_W-1:0] mode_q [DEPTH];
    logic [REV_MODE_W-1:0] mode_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;

    rev_xform #(
        .DATA_WIDTH  (DATA_WIDTH),
        .GROUP_WIDTH (GROUP_WIDTH)
    ) u_xform (
        .din  (bus.in_data),
        .mode (rev_mode_t'(bus.in_mode)),
        .dout (xdata)
    );

    assign bus.in_ready  = level_q < LW'(DEPTH);
    assign bus.out_valid = level_q != '0;
    assign bus.out_data  = data_q[rd_ptr_q];
    assign bus.out_mode  = mode_q[rd_ptr_q];
    assign bus.level     = level_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        data_d = data_q;
        mode_d = mode_q;
        if (push) begin
            data_d[wr_ptr_q] = xdata;
            mode_d[wr_ptr_q] = bus.in_mode;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q   <= '{default: '0};
            mode_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            data_q   <= data_d;
            mode_q   <= mode_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef FORMAL
    always @(posedge clk) begin
        if (resetn) begin
            assert (level_q <= LW'(DEPTH));
            assert (bus.in_ready == (level_q < LW'(DEPTH)));
            cover (level_q == LW'(DEPTH));
            cover (push && pop);
        end
    end
`endif

endmodule

// File: tb/tb_rev_stream.sv
// tb_rev_stream: directed vector table, handshake corner sequences and a random-stall scoreboard for rev_stream.
module tb_rev_stream;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    rev_stream_if #(.DATA_WIDTH(8), .DEPTH(2)) bus ();

    rev_stream #(
        .DATA_WIDTH  (8),
        .GROUP_WIDTH (4),
        .DEPTH       (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] din;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [7];
    logic [9:0] q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] n);
        return {n[0], n[1], n[2], n[3]};
    endfunction

    function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] m);
        case (m)
            2'd1:    return {rev4(d[3:0]), rev4(d[7:4])};
            2'd2:    return {d[3:0], d[7:4]};
            2'd3:    return {rev4(d[7:4]), rev4(d[3:0])};
            default: return d;
        endcase
    endfunction

    task automatic push_hold(input logic [7:0] d, input logic [1:0] m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h12, 2'd0, 8'h12};
        vecs[1] = '{8'h12, 2'd1, 8'h48};
        vecs[2] = '{8'h12, 2'd2, 8'h21};
        vecs[3] = '{8'h12, 2'd3, 8'h84};
        vecs[4] = '{8'h01, 2'd1, 8'h80};
        vecs[5] = '{8'hA5, 2'd2, 8'h5A};
        vecs[6] = '{8'hF0, 2'd3, 8'hF0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;

        #3;
        check("rst_level", 32'(bus.level), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_mode", 32'(bus.out_mode), 0);
        step();
        resetn = 1'b1;
        step();

        // Back-to-back pushes with the consumer always ready: each word is head one cycle after its push.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vecs[i].din;
            bus.in_mode  = vecs[i].mode;
            step();
            check("vec_valid", 32'(bus.out_valid), 1);
            check("vec_data", 32'(bus.out_data), 32'(vecs[i].exp));
            check("vec_mode", 32'(bus.out_mode), 32'(vecs[i].mode));
            check("vec_level", 32'(bus.level), 1);
        end
        bus.in_valid = 1'b0;
        step();
        check("vec_drain", 32'(bus.out_valid), 0);

        // Back-pressure.
        bus.out_ready = 1'b0;
        push_hold(8'h01, 2'd0);
        push_hold(8'h02, 2'd0);
        check("bp_level", 32'(bus.level), 2);
        check("bp_in_ready", 32'(bus.in_ready), 0);
        push_hold(8'h03, 2'd0);
        check("bp_no_push_level", 32'(bus.level), 2);
        check("bp_head", 32'(bus.out_data), 8'h01);
        bus.out_ready = 1'b1;
        step();
        check("bp_second", 32'(bus.out_data), 8'h02);
        check("bp_in_ready_after", 32'(bus.in_ready), 1);
        check("bp_level1", 32'(bus.level), 1);
        step();
        check("bp_empty", 32'(bus.out_valid), 0);

        // Full with simultaneous pop: no pass-through.
        bus.out_ready = 1'b0;
        push_hold(8'h11, 2'd0);
        push_hold(8'h22, 2'd0);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h33;
        bus.in_mode   = 2'd0;
        bus.out_ready = 1'b1;
        step();
        check("full_pop_level", 32'(bus.level), 1);
        check("full_pop_head", 32'(bus.out_data), 8'h22);
        check("full_pop_in_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        check("full_next_level", 32'(bus.level), 1);
        check("full_next_head", 32'(bus.out_data), 8'h33);
        step();
        check("full_drain", 32'(bus.level), 0);

        // Random stall against a reference queue.
        begin
            int sent = 0;
            int cyc = 0;
            logic pu, po;
            q.delete();
            while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
                bus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                bus.in_data   = 8'($urandom);
                bus.in_mode   = 2'($urandom_range(0, 3));
                bus.out_ready = $urandom_range(0, 3) != 0;
                check("rnd_level", 32'(bus.level), 32'(q.size()));
                pu = bus.in_valid && bus.in_ready;
                po = bus.out_valid && bus.out_ready;
                if (po) begin
                    if (q.size() == 0) begin
                        n_total++;
                        $display("FAIL rnd_underflow: got a word expected none");
                    end else check("rnd_word", 32'({bus.out_mode, bus.out_data}), 32'(q.pop_front()));
                end
                if (pu) begin
                    q.push_back({bus.in_mode, model(bus.in_data, bus.in_mode)});
                    sent++;
                end
                step();
                cyc++;
            end
            bus.in_valid = 1'b0;
            check("rnd_all_sent", 32'(sent), 1000);
            check("rnd_queue_empty", 32'(q.size()), 0);
        end

        // Reset mid-stream.
        bus.out_ready = 1'b0;
        push_hold(8'h5A, 2'd0);
        push_hold(8'h7E, 2'd1);
        check("mid_level_before", 32'(bus.level), 2);
        resetn = 1'b0;
        #1;
        check("mid_out_valid", 32'(bus.out_valid), 0);
        check("mid_out_data", 32'(bus.out_data), 0);
        check("mid_level", 32'(bus.level), 0);
        check("mid_in_ready", 32'(bus.in_ready), 1);
        step();
        resetn = 1'b1;
        step();
        bus.out_ready = 1'b1;
        push_hold(8'hC3, 2'd1);
        check("post_rst_valid", 32'(bus.out_valid), 1);
        check("post_rst_data", 32'(bus.out_data), 8'hC3);
        check("post_rst_mode", 32'(bus.out_mode), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rev_stream.md
# rev_stream

Streaming, parametrised bit-reordering unit with valid/ready handshake on both sides. Each accepted word is transformed by a per-word mode (pass, full bit reverse, group-order reverse, or bit reverse within groups) and queued in a small output FIFO. It sits between a producer and consumer in a data path where endianness or bit-order conversion must tolerate back-pressure without dropping words.

## Interface
- `DATA_WIDTH`, 8, word width in bits; ≥2.
- `GROUP_WIDTH`, 4, group size for group modes; must divide `DATA_WIDTH` and be ≥1.
- `DEPTH`, 2, output FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  producer presents a word.
- `in_ready`  out  1  unit can accept a word this cycle.
- `in_data`  in  DATA_WIDTH  input word.
- `in_mode`  in  2  transform select, sampled with the word.
- `out_valid`  out  1  head-of-FIFO word available.
- `out_ready`  in  1  consumer takes the head word.
- `out_data`  out  DATA_WIDTH  transformed head word.
- `out_mode`  out  2  mode the head word was transformed with.
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Modes: 0 PASS `out=in`; 1 BIT_REV `out[i]=in[DATA_WIDTH-1-i]`; 2 GROUP_REV: group g moves to group G-1-g, bit order inside each group unchanged (G=`DATA_WIDTH/GROUP_WIDTH`); 3 IN_GROUP_REV: group order unchanged, bits inside each group reversed.
- Identity: BIT_REV equals GROUP_REV applied after IN_GROUP_REV. When `GROUP_WIDTH==DATA_WIDTH`, GROUP_REV equals PASS and IN_GROUP_REV equals BIT_REV. When `GROUP_WIDTH==1`, GROUP_REV equals BIT_REV and IN_GROUP_REV equals PASS.
- The transform is applied to `in_data` before storage; the FIFO stores the transformed word and its 2-bit mode.
- Push: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- `in_ready = (level < DEPTH)`. There is no pass-through at full: a pop in the same cycle does not raise `in_ready`.
- `out_valid = (level != 0)`. `out_data`/`out_mode` show the head entry. When empty they show the last stored contents of the read-pointer entry, which are 0 after reset.
- Simultaneous push and pop: `level` unchanged, both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is tracked separately to distinguish full from empty.
- Words leave in acceptance order. No word is dropped or duplicated under any pattern of `in_valid` or `out_ready`.

## Timing
- Reset (async assert, sync-safe deassert by the system): `level=0`, pointers=0, all FIFO entries=0, `out_valid=0`, `out_data=0`, `out_mode=0`, `in_ready=1`.
- Reset mid-operation discards all queued words immediately on assertion.
- Latency: a word accepted at edge N is visible with `out_valid=1` in the cycle after edge N.
- Throughput: one word per cycle sustained while `out_ready=1` and the FIFO is not full.
- `in_ready` and `out_valid` are functions of registered `level` only. There is no combinational path from `out_ready` to `in_ready` or from `in_valid` to `out_valid`.
- `in_data` and `in_mode` are sampled only on a push edge. Their values outside push cycles are ignored.

## Structure
- Package `rev_pkg`:
  - enum typedef `rev_mode_t` {`REV_PASS`, `REV_BIT`, `REV_GROUP`, `REV_IN_GROUP`} (2 bits);
  - localparam helpers for group count and pointer width.
- Sub-module `rev_xform`: purely combinational transform, parameters `DATA_WIDTH` and `GROUP_WIDTH`, ports `din`, `mode`, `dout`. It is built from generate loops and holds no state.
- `rev_stream` contains the FIFO storage, pointers, `level` and the handshake logic, and instantiates `rev_xform` once on the input side.
- Formal, guarded by `FORMAL`:
  - assert `level<=DEPTH`;
  - assert `in_ready==(level<DEPTH)`;
  - assert BIT_REV maps `dout[0]==din[DATA_WIDTH-1]`;
  - cover full FIFO;
  - cover simultaneous push and pop.

## Test plan
All scenarios use defaults (8/4/2).
- Mode sweep: push 8'h12 with modes 0,1,2,3, `out_ready=1` -> outputs 8'h12, 8'h48, 8'h21, 8'h84 in order, each one cycle after its push, `out_mode` matching.
- BIT_REV 8'h01 -> 8'h80; GROUP_REV 8'hA5 -> 8'h5A; IN_GROUP_REV 8'hF0 -> 8'hF0.
- Back-pressure: `out_ready=0`, push 8'h01, 8'h02 -> `level=2`, `in_ready=0`; a third push is not accepted. Raise `out_ready` -> 8'h01 then 8'h02, and `in_ready=1` the cycle after the first pop.
- Full with simultaneous pop: FIFO full, `out_ready=1`, `in_valid=1` -> no push that cycle, `level` goes 2→1, the next cycle accepts the word, and order is preserved.
- Random stall: 1000 random words and modes with random `in_valid`/`out_ready` -> the output stream matches a reference-model queue exactly.
- Reset mid-stream: assert `resetn=0` with `level=2` -> `out_valid=0`, `out_data=0`, `level=0`, `in_ready=1` immediately. After release, the first push of 8'hC3 in BIT_REV gives 8'hC3.
